// File: rtl/branch_target_predictor_if.sv
// IF-stage lookup and EX-stage resolution signals of the branch target predictor.
// The pipeline drives through the master modport. The predictor uses the slave modport.
interface branch_target_predictor_if;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] trap_raddr;
  logic [31:0] PC_IF;
  logic [31:0] IM_IF;
  logic        jump_ena_IF;
  logic        jump_alw_IF;
  logic        jump_ind_IF;
  logic        trap_ret_IF;
  logic        call_IF;
  logic        ret_IF;
  logic        jump_pred_IF;
  logic [31:0] jump_addr_IF;
  logic [31:0] PC_EX;
  logic        jump_ena_EX;
  logic        jump_alw_EX;
  logic        jump_ind_EX;
  logic        jump_taken_EX;
  logic [31:0] jump_addr_EX;

  modport master (
    output valid_in, ready_in, trap_raddr, PC_IF, IM_IF,
    output jump_ena_IF, jump_alw_IF, jump_ind_IF, trap_ret_IF, call_IF, ret_IF,
    output PC_EX, jump_ena_EX, jump_alw_EX, jump_ind_EX, jump_taken_EX, jump_addr_EX,
    input  jump_pred_IF, jump_addr_IF
  );

  modport slave (
    input  valid_in, ready_in, trap_raddr, PC_IF, IM_IF,
    input  jump_ena_IF, jump_alw_IF, jump_ind_IF, trap_ret_IF, call_IF, ret_IF,
    input  PC_EX, jump_ena_EX, jump_alw_EX, jump_ind_EX, jump_taken_EX, jump_addr_EX,
    output jump_pred_IF, jump_addr_IF
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Gshare direction predictor with a direct-mapped BTB for indirect jumps and a
// speculative return address stack. Prediction is combinational; EX resolution trains.
module branch_target_predictor #(
  parameter int IDX_BITS  = 6,
  parameter int HIST_BITS = 6,
  parameter int CNT_BITS  = 2,
  parameter int BTB_BITS  = 4,
  parameter int RAS_DEPTH = 4
) (
  input logic                       clk,
  input logic                       reset,
  branch_target_predictor_if.slave  bus
);
  localparam int PHT_SIZE = 1 << IDX_BITS;
  localparam int BTB_SIZE = 1 << BTB_BITS;
  localparam int TAG_BITS = 30 - BTB_BITS;
  localparam int PTR_BITS = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W    = $clog2(RAS_DEPTH + 1);

  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]    RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [CNT_BITS-1:0] pht [PHT_SIZE];
  logic [HIST_BITS-1:0] ghr;

  logic [BTB_SIZE-1:0] btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [BTB_SIZE];
  logic [31:0]         btb_target [BTB_SIZE];

  logic [31:0]         ras [RAS_DEPTH];
  logic [PTR_BITS-1:0] ras_top;
  logic [CNT_W-1:0]    ras_count;

  logic [IDX_BITS-1:0] r_idx, w_idx;
  logic [BTB_BITS-1:0] btb_r_idx, btb_w_idx;
  logic                btb_hit, ras_nonempty, pht_taken;
  logic                if_fire, pht_upd, btb_upd;
  logic                ras_push, ras_pop, ras_replace;
  logic [31:0]         link_addr;
  logic                unused_pc_ex_lsbs;

  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_BITS'(1);
  endfunction

  function automatic logic [PTR_BITS-1:0] ptr_dec(input logic [PTR_BITS-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_BITS'(1);
  endfunction

  assign r_idx     = bus.PC_IF[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
  assign w_idx     = bus.PC_EX[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
  assign btb_r_idx = bus.PC_IF[BTB_BITS+1:2];
  assign btb_w_idx = bus.PC_EX[BTB_BITS+1:2];

  assign btb_hit      = btb_valid[btb_r_idx] && (btb_tag[btb_r_idx] == bus.PC_IF[31:BTB_BITS+2]);
  assign ras_nonempty = (ras_count != '0);
  assign pht_taken    = pht[r_idx][CNT_BITS-1];
  assign link_addr    = bus.PC_IF + 32'd4;

  assign if_fire = bus.valid_in && bus.ready_in && bus.jump_ena_IF;
  assign pht_upd = bus.ready_in && bus.jump_ena_EX && !bus.jump_alw_EX;
  assign btb_upd = bus.ready_in && bus.jump_ena_EX && bus.jump_ind_EX && bus.jump_taken_EX;

  // A call+ret pair on an empty stack degenerates into a plain push.
  assign ras_push    = if_fire && bus.call_IF && (!bus.ret_IF || !ras_nonempty);
  assign ras_replace = if_fire && bus.call_IF && bus.ret_IF && ras_nonempty;
  assign ras_pop     = if_fire && bus.ret_IF && !bus.call_IF && ras_nonempty;

  assign unused_pc_ex_lsbs = &{1'b0, bus.PC_EX[1:0]};

  // NOTE: every signal driven from always_comb gets its default first, so no path can infer a latch.
  always_comb begin
    bus.jump_addr_IF = bus.PC_IF + bus.IM_IF;
    if (bus.trap_ret_IF)                    bus.jump_addr_IF = bus.trap_raddr;
    else if (bus.ret_IF && ras_nonempty)    bus.jump_addr_IF = ras[ras_top];
    else if (bus.jump_ind_IF && btb_hit)    bus.jump_addr_IF = btb_target[btb_r_idx];
  end

  assign bus.jump_pred_IF = bus.valid_in && bus.jump_ena_IF &&
                            ( bus.trap_ret_IF
                           || (bus.jump_alw_IF && !bus.jump_ind_IF)
                           || (bus.jump_ind_IF &&  bus.ret_IF && ras_nonempty)
                           || (bus.jump_ind_IF && !bus.ret_IF && btb_hit)
                           || (!bus.jump_alw_IF && pht_taken));

  // NOTE: counters and valid bits carry architectural reset values and are cleared here;
  // BTB tag/target and RAS payload are only read behind a valid bit or count, so they have no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CNT_INIT;
      ghr <= '0;
    end else if (pht_upd) begin
      if (bus.jump_taken_EX) begin
        if (pht[w_idx] != CNT_MAX) pht[w_idx] <= pht[w_idx] + CNT_BITS'(1);
      end else begin
        if (pht[w_idx] != '0) pht[w_idx] <= pht[w_idx] - CNT_BITS'(1);
      end
      ghr <= (ghr << 1) | HIST_BITS'(bus.jump_taken_EX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (btb_upd) begin
      btb_valid[btb_w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_upd) begin
      btb_tag[btb_w_idx]    <= bus.PC_EX[31:BTB_BITS+2];
      btb_target[btb_w_idx] <= bus.jump_addr_EX;
    end
  end

  // Pushing onto a full stack silently overwrites the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_top   <= '0;
      ras_count <= '0;
    end else if (ras_push) begin
      ras_top <= ptr_inc(ras_top);
      if (ras_count != RAS_FULL) ras_count <= ras_count + CNT_W'(1);
    end else if (ras_pop) begin
      ras_top   <= ptr_dec(ras_top);
      ras_count <= ras_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push)         ras[ptr_inc(ras_top)] <= link_addr;
    else if (ras_replace) ras[ras_top]          <= link_addr;
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a reference model built on plain arrays
// and a queue, checked every cycle, plus hand-computed expectations at key points.
module tb_branch_target_predictor;
  localparam int IDX_BITS  = 6;
  localparam int HIST_BITS = 6;
  localparam int CNT_BITS  = 2;
  localparam int BTB_BITS  = 4;
  localparam int RAS_DEPTH = 4;
  localparam int PHT_N     = 1 << IDX_BITS;
  localparam int BTB_N     = 1 << BTB_BITS;
  localparam int CMAX      = (1 << CNT_BITS) - 1;
  localparam int CINIT     = 1 << (CNT_BITS - 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  branch_target_predictor_if bus();

  branch_target_predictor #(
    .IDX_BITS (IDX_BITS),
    .HIST_BITS(HIST_BITS),
    .CNT_BITS (CNT_BITS),
    .BTB_BITS (BTB_BITS),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model state
  int          m_pht [PHT_N];
  int          m_ghr;
  bit          m_bv  [BTB_N];
  int unsigned m_tag [BTB_N];
  logic [31:0] m_tgt [BTB_N];
  logic [31:0] m_ras [$];
  int          m_w;
  int          m_b;

  function automatic void model_reset();
    for (int i = 0; i < PHT_N; i++) m_pht[i] = CINIT;
    for (int i = 0; i < BTB_N; i++) m_bv[i] = 1'b0;
    m_ghr = 0;
    m_ras.delete();
  endfunction

  function automatic void model_pred(output bit p, output logic [31:0] a);
    int  ridx;
    int  bi;
    bit  hit;
    bit  rv;
    ridx = int'((bus.PC_IF >> 2) % PHT_N) ^ m_ghr;
    bi   = int'((bus.PC_IF >> 2) % BTB_N);
    hit  = m_bv[bi] && (m_tag[bi] == (bus.PC_IF >> (BTB_BITS + 2)));
    rv   = m_ras.size() > 0;
    if (bus.trap_ret_IF)                  a = bus.trap_raddr;
    else if (bus.ret_IF && rv)            a = m_ras[m_ras.size()-1];
    else if (bus.jump_ind_IF && hit)      a = m_tgt[bi];
    else                                  a = bus.PC_IF + bus.IM_IF;
    p = bus.valid_in && bus.jump_ena_IF &&
        (bus.trap_ret_IF || (bus.jump_alw_IF && !bus.jump_ind_IF) ||
         (bus.jump_ind_IF && bus.ret_IF && rv) || (bus.jump_ind_IF && !bus.ret_IF && hit) ||
         (!bus.jump_alw_IF && m_pht[ridx] >= CINIT));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else if (bus.ready_in) begin
      if (bus.jump_ena_EX && !bus.jump_alw_EX) begin
        m_w = int'((bus.PC_EX >> 2) % PHT_N) ^ m_ghr;
        if (bus.jump_taken_EX) m_pht[m_w] = (m_pht[m_w] < CMAX) ? m_pht[m_w] + 1 : CMAX;
        else                   m_pht[m_w] = (m_pht[m_w] > 0) ? m_pht[m_w] - 1 : 0;
        m_ghr = ((m_ghr << 1) | int'(bus.jump_taken_EX)) % (1 << HIST_BITS);
      end
      if (bus.jump_ena_EX && bus.jump_ind_EX && bus.jump_taken_EX) begin
        m_b = int'((bus.PC_EX >> 2) % BTB_N);
        m_bv[m_b]  = 1'b1;
        m_tag[m_b] = bus.PC_EX >> (BTB_BITS + 2);
        m_tgt[m_b] = bus.jump_addr_EX;
      end
      if (bus.valid_in && bus.jump_ena_IF) begin
        if (bus.call_IF && bus.ret_IF) begin
          if (m_ras.size() == 0) m_ras.push_back(bus.PC_IF + 32'd4);
          else m_ras[m_ras.size()-1] = bus.PC_IF + 32'd4;
        end else if (bus.call_IF) begin
          m_ras.push_back(bus.PC_IF + 32'd4);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (bus.ret_IF && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
    end
  end

  // Outputs are combinational and meaningful every cycle outside reset.
  bit          c_pred;
  logic [31:0] c_addr;
  always @(negedge clk) begin
    if (!reset) begin
      model_pred(c_pred, c_addr);
      check("cmp_pred", 32'(bus.jump_pred_IF), 32'(c_pred));
      check("cmp_addr", bus.jump_addr_IF, c_addr);
    end
  end

  task automatic clear_inputs();
    bus.valid_in = 1'b0;  bus.trap_raddr = '0;  bus.PC_IF = '0;  bus.IM_IF = '0;
    bus.jump_ena_IF = 1'b0; bus.jump_alw_IF = 1'b0; bus.jump_ind_IF = 1'b0;
    bus.trap_ret_IF = 1'b0; bus.call_IF = 1'b0; bus.ret_IF = 1'b0;
    bus.PC_EX = '0; bus.jump_ena_EX = 1'b0; bus.jump_alw_EX = 1'b0;
    bus.jump_ind_EX = 1'b0; bus.jump_taken_EX = 1'b0; bus.jump_addr_EX = '0;
  endtask

  task automatic set_if(input logic [31:0] pc, input logic [31:0] im,
                        input bit alw, input bit ind, input bit call, input bit ret, input bit trap);
    bus.valid_in = 1'b1; bus.PC_IF = pc; bus.IM_IF = im; bus.jump_ena_IF = 1'b1;
    bus.jump_alw_IF = alw; bus.jump_ind_IF = ind; bus.call_IF = call;
    bus.ret_IF = ret; bus.trap_ret_IF = trap;
  endtask

  task automatic set_ex(input logic [31:0] pc, input bit alw, input bit ind,
                        input bit taken, input logic [31:0] addr);
    bus.PC_EX = pc; bus.jump_ena_EX = 1'b1; bus.jump_alw_EX = alw;
    bus.jump_ind_EX = ind; bus.jump_taken_EX = taken; bus.jump_addr_EX = addr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input bit p, input logic [31:0] a);
    check({name, "_pred"}, 32'(bus.jump_pred_IF), 32'(p));
    check({name, "_addr"}, bus.jump_addr_IF, a);
  endtask

  logic [31:0] ret_exp [4];

  initial begin
    ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24};
    clear_inputs();
    bus.ready_in = 1'b1;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and the first prediction: weakly taken
    clear_inputs(); set_if(32'h100, 32'h40, 0, 0, 0, 0, 0);
    sample();
    expect_out("br_reset", 1'b1, 32'h140);
    check("reset_ghr", 32'(dut.ghr), 32'd0);
    check("reset_pht0", 32'(dut.pht[0]), 32'd2);
    check("reset_ras_count", 32'(dut.ras_count), 32'd0);

    // Two not-taken resolutions drive the counter to 0
    next_cycle(); clear_inputs(); set_ex(32'h100, 0, 0, 0, 32'h0); sample();
    next_cycle(); clear_inputs(); set_ex(32'h100, 0, 0, 0, 32'h0); sample();
    check("nt1_pht0", 32'(dut.pht[0]), 32'd1);
    next_cycle(); clear_inputs(); set_if(32'h100, 32'h40, 0, 0, 0, 0, 0); sample();
    expect_out("br_nt", 1'b0, 32'h140);
    check("nt2_pht0", 32'(dut.pht[0]), 32'd0);
    check("nt2_ghr", 32'(dut.ghr), 32'd0);

    // Taken resolution shifts a 1 into the history
    next_cycle(); clear_inputs(); set_ex(32'h100, 0, 0, 1, 32'h140); sample();
    next_cycle(); clear_inputs(); sample();
    check("tk_ghr", 32'(dut.ghr), 32'd1);
    check("tk_pht0", 32'(dut.pht[0]), 32'd1);

    // JALR through the BTB: miss, train, hit, alias miss
    next_cycle(); clear_inputs(); set_if(32'h200, 32'h0, 1, 1, 0, 0, 0); sample();
    expect_out("jalr_miss", 1'b0, 32'h200);
    next_cycle(); clear_inputs(); set_ex(32'h200, 1, 1, 1, 32'h8000); sample();
    next_cycle(); clear_inputs(); set_if(32'h200, 32'h0, 1, 1, 0, 0, 0); sample();
    expect_out("jalr_hit", 1'b1, 32'h8000);
    next_cycle(); clear_inputs(); set_if(32'h240, 32'h0, 1, 1, 0, 0, 0); sample();
    expect_out("jalr_alias", 1'b0, 32'h240);

    // Five calls into a four-deep stack, then five returns
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); clear_inputs(); set_if(32'(k * 16), 32'h100, 1, 0, 1, 0, 0); sample();
      expect_out("call", 1'b1, 32'(k * 16 + 256));
    end
    for (int r = 0; r < 5; r++) begin
      next_cycle(); clear_inputs(); set_if(32'h600, 32'h0, 1, 1, 0, 1, 0); sample();
      if (r == 0) check("ras_full_count", 32'(dut.ras_count), 32'd4);
      if (r < 4) expect_out("ret", 1'b1, ret_exp[r]);
      else       expect_out("ret_empty", 1'b0, 32'h600);
    end

    // Trap return wins over the RAS but still pops it
    next_cycle(); clear_inputs(); set_if(32'h70, 32'h10, 1, 0, 1, 0, 0); sample();
    check("empty_pop_count", 32'(dut.ras_count), 32'd0);
    next_cycle(); clear_inputs(); set_if(32'h900, 32'h0, 1, 0, 0, 1, 1);
    bus.trap_raddr = 32'h3000; sample();
    expect_out("mret", 1'b1, 32'h3000);
    check("mret_pre_count", 32'(dut.ras_count), 32'd1);
    next_cycle(); clear_inputs(); sample();
    check("mret_pop_count", 32'(dut.ras_count), 32'd0);

    // ready_in low freezes all state while outputs still follow the inputs
    next_cycle(); clear_inputs(); bus.ready_in = 1'b0;
    set_if(32'h80, 32'h8, 1, 0, 1, 0, 0); set_ex(32'h100, 0, 0, 1, 32'h140); sample();
    expect_out("frz_out", 1'b1, 32'h88);
    next_cycle(); sample();
    check("frz_ghr", 32'(dut.ghr), 32'd1);
    check("frz_pht0", 32'(dut.pht[0]), 32'd1);
    check("frz_pht1", 32'(dut.pht[1]), 32'd2);
    check("frz_ras_count", 32'(dut.ras_count), 32'd0);
    expect_out("frz_out2", 1'b1, 32'h88);

    // Asynchronous reset in the middle of the frozen cycle
    #2 reset = 1'b1;
    #1;
    check("arst_ghr", 32'(dut.ghr), 32'd0);
    check("arst_pht0", 32'(dut.pht[0]), 32'd2);
    clear_inputs(); set_if(32'h200, 32'h0, 1, 1, 0, 0, 0);
    #1;
    expect_out("arst_btb", 1'b0, 32'h200);

    next_cycle(); reset = 1'b0; bus.ready_in = 1'b1;
    clear_inputs(); set_if(32'h100, 32'h40, 0, 0, 0, 0, 0); sample();
    expect_out("post_reset", 1'b1, 32'h140);
    next_cycle(); clear_inputs(); sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
